// File: rtl/cnn_acc_pkg.sv
// Shared definitions for the CNN accelerator datapath.
// Contents: feeder_state_t (feeder phase encoding) and the default array/FIFO
// dimensions used by the controller, the feeder and the PE array.
package cnn_acc_pkg;

    localparam int ROWS_DEF       = 4;
    localparam int DW_DEF         = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        W_LOAD,
        W_HOLD,
        COMPUTE,
        DRAIN
    } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO used by the systolic feeder for weight rows and activations.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   push_valid/ready  write handshake; ready is !full from registered pointers
//   push_data         write data
//   pop               read strobe; ignored while empty
//   empty             no entry available
//   head              oldest entry (meaningful only while !empty)
module feeder_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full (MSBs differ) from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             full;
    logic             push;
    logic             take;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign push_ready = !full;
    assign push       = push_valid && !full;
    assign take       = pop && !empty;
    assign head       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (take) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/systolic_feeder.sv
// Feeder between the load/compute controller and the PE array.
// Buffers weight rows and activation vectors, loads exactly ROWS weight rows
// per tile, and streams activations with lane i delayed by i extra cycles.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for ctrl_in=1 to start a weight load
// W_LOAD  | popping weight rows until ROWS are driven; ctrl_in=0 aborts
// W_HOLD  | full tile loaded, waiting for ctrl_in=0
// COMPUTE | popping one activation vector per cycle when available
// DRAIN   | no pops; waits for the skew chains to empty before reloading
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ctrl_in                       phase: 1 = weight load, 0 = compute
//   w_valid/w_ready/w_data        weight-row write side
//   a_valid/a_ready/a_data        activation write side (lane i = [i*DW +: DW])
//   pe_w_load/pe_w_data           weight row to the array
//   pe_a_valid/pe_a_data          skewed activation lanes
//   load_done                     pulse with the ROWS-th weight row
//   err_short                     pulse after a load is aborted
//   busy                          state != IDLE
module systolic_feeder
    import cnn_acc_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctrl_in,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [ROWS*DW-1:0] w_data,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [ROWS*DW-1:0] a_data,
    output logic               pe_w_load,
    output logic [ROWS*DW-1:0] pe_w_data,
    output logic [ROWS-1:0]    pe_a_valid,
    output logic [ROWS*DW-1:0] pe_a_data,
    output logic               load_done,
    output logic               err_short,
    output logic               busy
);

    localparam int VW = ROWS * DW;
    localparam int CW = $clog2(ROWS + 1);

    feeder_state_t state;
    logic [CW-1:0] row_cnt;
    logic          w_empty;
    logic          a_empty;
    logic [VW-1:0] w_head;
    logic [VW-1:0] a_head;
    logic          w_pop;
    logic          a_pop;

    feeder_fifo #(.WIDTH(VW), .DEPTH(DEPTH)) u_w_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_valid(w_valid),
        .push_ready(w_ready),
        .push_data (w_data),
        .pop       (w_pop),
        .empty     (w_empty),
        .head      (w_head)
    );

    feeder_fifo #(.WIDTH(VW), .DEPTH(DEPTH)) u_a_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_valid(a_valid),
        .push_ready(a_ready),
        .push_data (a_data),
        .pop       (a_pop),
        .empty     (a_empty),
        .head      (a_head)
    );

    // The abort cycle (ctrl_in=0 in W_LOAD) and the COMPUTE->DRAIN cycle never pop.
    assign w_pop = (state == W_LOAD) && ctrl_in && !w_empty;
    assign a_pop = (state == COMPUTE) && !ctrl_in && !a_empty;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            pe_w_load <= 1'b0;
            pe_w_data <= '0;
            load_done <= 1'b0;
            err_short <= 1'b0;
        end else begin
            pe_w_load <= w_pop;
            load_done <= 1'b0;
            err_short <= 1'b0;
            if (w_pop) pe_w_data <= w_head;

            case (state)
                IDLE: begin
                    if (ctrl_in) begin
                        state   <= W_LOAD;
                        row_cnt <= '0;
                    end
                end
                W_LOAD: begin
                    if (!ctrl_in) begin
                        err_short <= 1'b1;
                        row_cnt   <= '0;
                        state     <= IDLE;
                    end else if (!w_empty) begin
                        row_cnt <= row_cnt + 1'b1;
                        if (row_cnt == CW'(ROWS - 1)) begin
                            load_done <= 1'b1;
                            state     <= W_HOLD;
                        end
                    end
                end
                W_HOLD: begin
                    if (!ctrl_in) state <= COMPUTE;
                end
                COMPUTE: begin
                    if (ctrl_in) state <= DRAIN;
                end
                DRAIN: begin
                    // Registered lane valids: the tail of the last vector must
                    // have left lane ROWS-1 before the array is reloaded.
                    if (!ctrl_in) begin
                        state <= COMPUTE;
                    end else if (pe_a_valid == '0) begin
                        state   <= W_LOAD;
                        row_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [DW-1:0] sd [i+1];
        logic          sv [i+1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= i; k++) begin
                    sd[k] <= '0;
                    sv[k] <= 1'b0;
                end
            end else begin
                sv[0] <= a_pop;
                sd[0] <= a_pop ? a_head[i*DW +: DW] : '0;
                for (int k = 1; k <= i; k++) begin
                    sd[k] <= sd[k-1];
                    sv[k] <= sv[k-1];
                end
            end
        end

        assign pe_a_valid[i]          = sv[i];
        assign pe_a_data[i*DW +: DW]  = sd[i];
    end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
    import cnn_acc_pkg::*;

    localparam int ROWS  = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int VW    = ROWS * DW;
    localparam int NCYC  = 4096;

    logic            clk;
    logic            rst;
    logic            ctrl_in;
    logic            w_valid;
    logic            w_ready;
    logic [VW-1:0]   w_data;
    logic            a_valid;
    logic            a_ready;
    logic [VW-1:0]   a_data;
    logic            pe_w_load;
    logic [VW-1:0]   pe_w_data;
    logic [ROWS-1:0] pe_a_valid;
    logic [VW-1:0]   pe_a_data;
    logic            load_done;
    logic            err_short;
    logic            busy;

    systolic_feeder #(.ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ctrl_in   (ctrl_in),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .pe_w_load (pe_w_load),
        .pe_w_data (pe_w_data),
        .pe_a_valid(pe_a_valid),
        .pe_a_data (pe_a_data),
        .load_done (load_done),
        .err_short (err_short),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: FIFO contents as queues, phase as a small integer,
    // activation lanes as an expected-output timeline indexed by cycle.
    localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_COMP = 3, P_DRAIN = 4;
    logic [VW-1:0]   wq[$];
    logic [VW-1:0]   aq[$];
    int              m_phase;
    int              m_rows;
    int              cyc;
    logic            m_wl, m_ld, m_err;
    logic [VW-1:0]   m_wd;
    logic [ROWS-1:0] ev [NCYC];
    logic [VW-1:0]   ed [NCYC];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_all();
        check("busy",       64'(busy),       64'(m_phase != P_IDLE));
        check("w_ready",    64'(w_ready),    64'(wq.size() < DEPTH));
        check("a_ready",    64'(a_ready),    64'(aq.size() < DEPTH));
        check("pe_w_load",  64'(pe_w_load),  64'(m_wl));
        if (m_wl) check("pe_w_data", 64'(pe_w_data), 64'(m_wd));
        check("load_done",  64'(load_done),  64'(m_ld));
        check("err_short",  64'(err_short),  64'(m_err));
        check("pe_a_valid", 64'(pe_a_valid), 64'(ev[cyc]));
        check("pe_a_data",  64'(pe_a_data),  64'(ed[cyc]));
    endtask

    task automatic model_step();
        int            wsz;
        int            asz;
        logic [VW-1:0] v;
        wsz   = wq.size();
        asz   = aq.size();
        m_wl  = 1'b0;
        m_ld  = 1'b0;
        m_err = 1'b0;
        case (m_phase)
            P_IDLE: if (ctrl_in) begin m_phase = P_LOAD; m_rows = 0; end
            P_LOAD: begin
                if (!ctrl_in) begin
                    m_err = 1'b1; m_phase = P_IDLE; m_rows = 0;
                end else if (wsz > 0) begin
                    m_wd = wq.pop_front();
                    m_wl = 1'b1;
                    m_rows++;
                    if (m_rows == ROWS) begin m_ld = 1'b1; m_phase = P_HOLD; end
                end
            end
            P_HOLD: if (!ctrl_in) m_phase = P_COMP;
            P_COMP: begin
                if (ctrl_in) m_phase = P_DRAIN;
                else if (asz > 0) begin
                    v = aq.pop_front();
                    for (int i = 0; i < ROWS; i++) begin
                        ev[cyc+1+i][i]         = 1'b1;
                        ed[cyc+1+i][i*DW +: DW] = v[i*DW +: DW];
                    end
                end
            end
            P_DRAIN: begin
                if (!ctrl_in) m_phase = P_COMP;
                else if (ev[cyc] == '0) begin m_phase = P_LOAD; m_rows = 0; end
            end
            default: m_phase = P_IDLE;
        endcase
        if (w_valid && wsz < DEPTH) wq.push_back(w_data);
        if (a_valid && asz < DEPTH) aq.push_back(a_data);
        cyc++;
    endtask

    task automatic tick();
        if (cyc >= NCYC - ROWS - 2) begin
            $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, NCYC - ROWS - 2);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge clk);
        if (rst) model_step(); else cyc++;
        @(negedge clk);
        check_all();
    endtask

    task automatic set_in(input logic c, input logic wv, input logic [VW-1:0] wd,
                          input logic av, input logic [VW-1:0] ad);
        ctrl_in = c; w_valid = wv; w_data = wd; a_valid = av; a_data = ad;
    endtask

    task automatic wait_phase(input int p, input int budget);
        for (int k = 0; k < budget && m_phase != p; k++) tick();
        check("wait_phase", 64'(m_phase), 64'(p));
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        set_in(1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        check("rst_pe_w_load",  64'(pe_w_load),  64'(0));
        check("rst_pe_w_data",  64'(pe_w_data),  64'(0));
        check("rst_pe_a_valid", 64'(pe_a_valid), 64'(0));
        check("rst_pe_a_data",  64'(pe_a_data),  64'(0));
        check("rst_load_done",  64'(load_done),  64'(0));
        check("rst_err_short",  64'(err_short),  64'(0));
        check("rst_busy",       64'(busy),       64'(0));
        check("rst_w_ready",    64'(w_ready),    64'(1));
        check("rst_a_ready",    64'(a_ready),    64'(1));
        wq.delete();
        aq.delete();
        m_phase = P_IDLE; m_rows = 0;
        m_wl = 1'b0; m_ld = 1'b0; m_err = 1'b0; m_wd = '0;
        for (int k = cyc; k < NCYC; k++) begin ev[k] = '0; ed[k] = '0; end
        tick();
        tick();
        rst = 1'b1;
    endtask

    logic [VW-1:0] rows_a [4];

    initial begin
        rows_a[0] = 32'h01020304; rows_a[1] = 32'h05060708;
        rows_a[2] = 32'h090A0B0C; rows_a[3] = 32'h0D0E0F10;
        for (int k = 0; k < NCYC; k++) begin ev[k] = '0; ed[k] = '0; end
        cyc = 0;
        m_phase = P_IDLE; m_rows = 0;
        m_wl = 1'b0; m_ld = 1'b0; m_err = 1'b0; m_wd = '0;
        rst = 1'b1;
        set_in(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge clk);
        async_reset();
        tick();

        // Full load of four preloaded rows.
        for (int r = 0; r < 4; r++) begin set_in(1'b0, 1'b1, rows_a[r], 1'b0, '0); tick(); end
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        wait_phase(P_HOLD, 20);
        tick();

        // Fill the activation FIFO while holding, then one rejected extra write.
        for (int r = 0; r < DEPTH + 1; r++) begin
            set_in(1'b1, 1'b0, '0, 1'b1, (r == 0) ? 32'h44332211 : VW'($urandom()));
            tick();
        end
        set_in(1'b0, 1'b0, '0, 1'b0, '0);
        for (int r = 0; r < 14; r++) tick();

        // Random activation traffic in COMPUTE.
        for (int r = 0; r < 40; r++) begin
            set_in(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), VW'($urandom()));
            tick();
        end

        // Drain, then a load that stalls for five cycles mid-tile.
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        wait_phase(P_LOAD, 40);
        for (int r = 0; r < 2; r++) begin set_in(1'b1, 1'b1, VW'($urandom()), 1'b0, '0); tick(); end
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        for (int r = 0; r < 5; r++) tick();
        for (int r = 0; r < 2; r++) begin set_in(1'b1, 1'b1, VW'($urandom()), 1'b0, '0); tick(); end
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        wait_phase(P_HOLD, 20);

        // Short-load abort: two rows popped, two left for the next load.
        set_in(1'b0, 1'b0, '0, 1'b0, '0);
        wait_phase(P_COMP, 5);
        for (int r = 0; r < 4; r++) begin
            set_in(1'b0, 1'b1, VW'($urandom()), 1'($urandom_range(0, 1)), VW'($urandom()));
            tick();
        end
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        wait_phase(P_LOAD, 40);
        tick();
        tick();
        set_in(1'b0, 1'b0, '0, 1'b0, '0);
        tick();
        tick();
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        wait_phase(P_LOAD, 5);
        tick();
        tick();
        for (int r = 0; r < 2; r++) begin set_in(1'b1, 1'b1, VW'($urandom()), 1'b0, '0); tick(); end
        set_in(1'b1, 1'b0, '0, 1'b0, '0);
        wait_phase(P_HOLD, 20);

        // Reset with activations in flight.
        set_in(1'b0, 1'b0, '0, 1'b1, VW'($urandom()));
        for (int r = 0; r < 6; r++) begin a_data = VW'($urandom()); tick(); end
        async_reset();
        tick();

        // Mixed random phase traffic.
        ctrl_in = 1'b0;
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 7) == 0) ctrl_in = ~ctrl_in;
            w_valid = 1'($urandom_range(0, 1));
            w_data  = VW'($urandom());
            a_valid = 1'($urandom_range(0, 1));
            a_data  = VW'($urandom());
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Data feeder between the load/compute controller and the PE array. Buffers incoming weight rows and activation vectors in two small FIFOs, pushes exactly ROWS weight rows into the array during a weight-load phase, and streams activations with per-lane diagonal skew during the compute phase. `ctrl_in` is the controller's phase bit: 1 means weight load, 0 means partial-sum/compute.

## Interface
Parameters:
- ROWS, 4, PE array rows; also the number of weight rows per tile and the number of activation lanes
- DW, 8, bits per element
- DEPTH, 8, entries per FIFO; must be a power of 2 and at least 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- ctrl_in  in  1  phase from controller; 1 = weight load, 0 = compute
- w_valid / w_ready  in/out  1/1  weight-row write handshake
- w_data  in  ROWS*DW  one weight row
- a_valid / a_ready  in/out  1/1  activation write handshake
- a_data  in  ROWS*DW  one activation vector; lane i = bits [i*DW +: DW]
- pe_w_load  out  1  pe_w_data is valid this cycle
- pe_w_data  out  ROWS*DW  weight row to the array
- pe_a_valid  out  ROWS  per-lane activation valid
- pe_a_data  out  ROWS*DW  skewed activation lanes
- load_done  out  1  one-cycle pulse when the ROWS-th weight row is driven
- err_short  out  1  one-cycle pulse when a load is aborted
- busy  out  1  state != IDLE

## Operation
- Handshake rules:
  - Write accepted when valid && ready.
  - w_ready = !w_full and a_ready = !a_full. Neither depends on ctrl_in.
  - A write to a full FIFO is impossible by construction.
- States: IDLE, W_LOAD, W_HOLD, COMPUTE, DRAIN. Reset enters IDLE.
- IDLE: ctrl_in=1 -> W_LOAD with row counter cleared.
- W_LOAD:
  - Each cycle the weight FIFO is non-empty: pop one row and increment the counter.
  - Empty FIFO stalls the load with no error.
  - Pop that makes the count ROWS -> W_HOLD.
  - ctrl_in=0 with count<ROWS -> err_short pulse, counter cleared, go to IDLE. Rows already driven are not retracted.
- W_HOLD: no pops. ctrl_in=0 -> COMPUTE.
- COMPUTE:
  - Pop one activation vector every cycle the activation FIFO is non-empty.
  - ctrl_in=1 -> DRAIN, and no pop occurs in that same cycle.
- DRAIN: no pops. When pe_a_valid is all zeros and ctrl_in=1 -> W_LOAD with counter cleared. If ctrl_in=0 instead, return to COMPUTE.
- Skew pipeline:
  - Lane i has a shift chain of depth i+1, carrying data and a valid bit.
  - The chain shifts every cycle regardless of state.
  - A non-popping cycle inserts valid=0 with data held at 0.
- Activations are never popped outside COMPUTE. Weights are never popped outside W_LOAD.
- FIFO pointers: log2(DEPTH)+1 bits. The MSB distinguishes full from empty; the remaining bits wrap modulo DEPTH.
- Simultaneous write and pop on a full FIFO: the pop frees space only on the next cycle, because ready is registered from occupancy.
- Simultaneous write and pop on an empty FIFO: the pop does not happen; the written data is poppable the next cycle. There is no fall-through.

## Timing
- Reset values: pe_w_load=0, pe_w_data=0, pe_a_valid=0, pe_a_data=0, load_done=0, err_short=0, busy=0. Both FIFOs empty, w_ready=a_ready=1.
- Write accepted in cycle t -> entry poppable in cycle t+1.
- Weight pop in cycle t -> pe_w_load=1 and pe_w_data valid in cycle t+1. load_done is high in the same t+1 for the ROWS-th row.
- Activation pop in cycle t -> lane i valid in cycle t+1+i.
- err_short is asserted in the cycle after the abort is sampled.
- The transition out of DRAIN is evaluated on registered pe_a_valid. The minimum DRAIN length is ROWS cycles after the last pop.
- Mid-operation reset clears FIFOs, skew chains, counter and outputs immediately (asynchronous).

## Structure
- Package `cnn_acc_pkg` holds:
  - the state enum `feeder_state_t`
  - default constants `ROWS_DEF`, `DW_DEF` and `FIFO_DEPTH_DEF`
  - these are shared with the controller and the PE array
- One sub-module, `feeder_fifo`: a synchronous FIFO parameterised by width and depth, with valid/ready on the write side and pop/empty on the read side. It is instantiated twice, once with weight width and once with activation width (both ROWS*DW).
- The state machine, row counter and skew chains live in the top level.

## Test plan
- Reset: rst=0 mid-stream -> all outputs 0, w_ready=a_ready=1, busy=0 in the same cycle.
- Full load: preload 4 weight rows 0x01020304..0x0D0E0F10, ctrl_in=1 -> pe_w_load high 4 consecutive cycles with the rows in order, load_done on the 4th, state W_HOLD.
- Stalled load: 2 rows present, ctrl_in held at 1; the remaining 2 rows arrive 5 cycles later -> pe_w_load gap of 5 cycles, load_done on the 4th row, err_short=0.
- Short load abort: 2 rows loaded, ctrl_in drops -> err_short pulse once, state IDLE, 2 rows remain in the FIFO.
- Skew: in COMPUTE, push vector lanes {0x11,0x22,0x33,0x44} -> lane0=0x11 at t+1, lane1=0x22 at t+2, lane2=0x33 at t+3, lane3=0x44 at t+4.
- FIFO boundaries: write 8 activations with no pops -> a_ready=0 after the 8th. ctrl_in=1 from COMPUTE -> DRAIN lasts ≥4 cycles until pe_a_valid=0, then W_LOAD.
